// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 16x oversampling and a 2^FIFO_AW-entry first-word-fall-through FIFO.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit after the data bits (8E1).
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int FIFO_AW = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       s_tick,
    input  logic       rd_uart,
    output logic [7:0] r_data,
    output logic       rx_empty,
    output logic       rx_full,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    localparam int               DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] PTR_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [3:0]       S_MID     = 4'd7;
    localparam logic [3:0]       S_END     = 4'd15;
    localparam logic [3:0]       S_STOP    = 4'(SB_TICK - 1);
    localparam logic [2:0]       N_LAST    = 3'(DBIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // Data arrives LSB first into the top of the shift register, so short
    // frames end up left-aligned and must be shifted down.
    function automatic logic [7:0] align_byte(input logic [7:0] sr);
        return sr >> (8 - DBIT);
    endfunction

`ifdef UART_RX_PARITY_EN
    function automatic logic parity_ok(input logic [7:0] data, input logic pbit);
        return ~(^data ^ pbit);
    endfunction
`endif

    logic rx_p0, rx_s;

    state_t     state_q, state_d;
    logic [3:0] s_q, s_d;
    logic [2:0] n_q, n_d;
    logic [7:0] b_q, b_d;
    logic       done;

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic par_bad;
    logic pe_d;
    logic parity_err_q;
`endif

    logic fe_d, ov_d;
    logic frame_err_q, overrun_q;
    logic wr_en, rd_en;

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q, count;

    // ---- stage p0/p1: two-flop synchroniser, idle-high reset ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_s  <= rx_p0;
        end
    end

    // ---- frame FSM state register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            s_q     <= 4'd0;
            n_q     <= 3'd0;
            b_q     <= 8'd0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        done    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = 4'd0;
                end
            end
            START: begin
                if (s_tick) begin
                    // Mid-bit verification rejects short glitches on the line.
                    if (s_q == S_MID) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = 4'd0;
                            n_d     = 3'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_END) begin
                        s_d = 4'd0;
                        b_d = {rx_s, b_q[7:1]};
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_q == S_END) begin
                        s_d     = 4'd0;
                        par_d   = rx_s;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP) begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign par_bad = ~parity_ok(align_byte(b_q), par_q);
`endif

    // ---- frame completion: exactly one of error, overrun or write ----
    always_comb begin
        fe_d  = 1'b0;
        ov_d  = 1'b0;
        wr_en = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe_d  = 1'b0;
`endif
        if (done) begin
            if (!rx_s) begin
                fe_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad) begin
                pe_d = 1'b1;
`endif
            end else if (rx_full && !rd_uart) begin
                ov_d = 1'b1;
            end else begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q  <= fe_d;
            overrun_q    <= ov_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= pe_d;
`endif
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    // ---- FIFO: storage is left unreset, r_data is gated while empty ----
    assign rd_en = rd_uart && !rx_empty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[FIFO_AW-1:0]] <= align_byte(b_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    assign count    = wr_ptr_q - rd_ptr_q;
    assign rx_empty = (count == '0);
    assign rx_full  = (count == DEPTH_CNT);
    assign r_data   = rx_empty ? 8'h00 : mem[rd_ptr_q[FIFO_AW-1:0]];

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: random and directed frames checked against a queue-based model.
// Define UART_RX_PARITY_EN for both files to exercise the 8E1 build.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BIT_CLKS = 64;
    localparam int O_WR = 0, O_FE = 1, O_PE = 2, O_OV = 3;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       s_tick = 1'b0;
    logic       rd_uart = 1'b0;
    logic [7:0] r_data;
    logic       rx_empty, rx_full, frame_err, parity_err, overrun;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, wide_cnt = 0;
    logic fe_prev = 1'b0, pe_prev = 1'b0, ov_prev = 1'b0;
    logic [1:0] tick_div = 2'd0;
    logic [7:0] model_q[$];

    uart_rx dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .s_tick    (s_tick),
        .rd_uart   (rd_uart),
        .r_data    (r_data),
        .rx_empty  (rx_empty),
        .rx_full   (rx_full),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tick_div = tick_div + 2'd1;
        s_tick   = (tick_div == 2'd0);
    end

    always @(negedge clk) begin
        if (frame_err)  fe_cnt++;
        if (parity_err) pe_cnt++;
        if (overrun)    ov_cnt++;
        if ((frame_err && fe_prev) || (parity_err && pe_prev) || (overrun && ov_prev)) wide_cnt++;
        fe_prev = frame_err;
        pe_prev = parity_err;
        ov_prev = overrun;
    end

    // Reference: stop bit first, then even parity, then FIFO capacity decides the fate of a frame.
    function automatic int model_frame(input logic [7:0] d, input logic p, input logic stop);
        if (!stop) return O_FE;
        if (PAR_EN && ((^d) != p)) return O_PE;
        if (model_q.size() == 16) return O_OV;
        model_q.push_back(d);
        return O_WR;
    endfunction

    task automatic drive_frame(input logic [7:0] d, input logic p, input logic stop);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        if (PAR_EN) begin
            rx = p;
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = stop;
        repeat (stop ? BIT_CLKS : 40) @(negedge clk);
        rx = 1'b1;
        repeat (stop ? 16 : 80) @(negedge clk);
    endtask

    task automatic pop_pulse();
        rd_uart = 1'b1;
        @(negedge clk);
        rd_uart = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", rx_empty); end
        checks++; if (rx_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", rx_full); end
        checks++; if (r_data !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", r_data); end
        checks++; if ({frame_err, parity_err, overrun} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses got %b want 000", {frame_err, parity_err, overrun}); end
        reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        int o, fe0, pe0, ov0;
        pop_pulse();  // read while empty must be ignored
        checks++; if (rx_empty !== 1'b1 || rx_full !== 1'b0) begin
            errors++; $display("FAIL empty_read got empty=%b full=%b want 1 0", rx_empty, rx_full); end
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
        o = model_frame(8'hA5, 1'b0, 1'b1);
        drive_frame(8'hA5, 1'b0, 1'b1);
        checks++; if (o != O_WR || fe_cnt != fe0 || pe_cnt != pe0 || ov_cnt != ov0) begin
            errors++; $display("FAIL basic_pulses got fe=%0d pe=%0d ov=%0d want none", fe_cnt-fe0, pe_cnt-pe0, ov_cnt-ov0); end
        checks++; if (rx_empty !== 1'b0) begin errors++; $display("FAIL basic_empty got %b want 0", rx_empty); end
        checks++; if (r_data !== 8'hA5) begin errors++; $display("FAIL basic_rdata got %h want a5", r_data); end
        pop_pulse();
        void'(model_q.pop_front());
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL basic_pop got empty=%b want 1", rx_empty); end
    endtask

    task automatic test_glitch();
        int fe0, pe0, ov0;
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
        rx = 1'b0;
        repeat (12) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        checks++; if (fe_cnt != fe0 || pe_cnt != pe0 || ov_cnt != ov0) begin
            errors++; $display("FAIL glitch_pulses got fe=%0d pe=%0d ov=%0d want 0", fe_cnt-fe0, pe_cnt-pe0, ov_cnt-ov0); end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL glitch_empty got %b want 1", rx_empty); end
        void'(model_frame(8'h96, ^8'h96, 1'b1));
        drive_frame(8'h96, ^8'h96, 1'b1);
        checks++; if (rx_empty !== 1'b0 || r_data !== 8'h96) begin
            errors++; $display("FAIL glitch_next got empty=%b data=%h want 0 96", rx_empty, r_data); end
        pop_pulse();
        void'(model_q.pop_front());
    endtask

    task automatic test_frame_err();
        int o, fe0, pe0, ov0;
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
        o = model_frame(8'h3C, ^8'h3C, 1'b0);
        drive_frame(8'h3C, ^8'h3C, 1'b0);
        checks++; if (o != O_FE || fe_cnt - fe0 != 1 || pe_cnt != pe0 || ov_cnt != ov0) begin
            errors++; $display("FAIL frame_err got fe=%0d pe=%0d ov=%0d want 1 0 0", fe_cnt-fe0, pe_cnt-pe0, ov_cnt-ov0); end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL frame_err_empty got %b want 1", rx_empty); end
        checks++; if (wide_cnt != 0) begin errors++; $display("FAIL pulse_width got %0d wide want 0", wide_cnt); end
    endtask

    task automatic test_overrun();
        int o, ov0;
        logic [7:0] d;
        for (int i = 0; i < 17; i++) begin
            d = 8'(i);
            ov0 = ov_cnt;
            o = model_frame(d, ^d, 1'b1);
            drive_frame(d, ^d, 1'b1);
            if (i == 15) begin
                checks++; if (rx_full !== 1'b1) begin errors++; $display("FAIL full_after16 got %b want 1", rx_full); end
            end
            if (i == 16) begin
                checks++; if (o != O_OV || ov_cnt - ov0 != 1) begin
                    errors++; $display("FAIL overrun got %0d pulses want 1", ov_cnt - ov0); end
                checks++; if (rx_full !== 1'b1) begin errors++; $display("FAIL full_kept got %b want 1", rx_full); end
            end
        end
        for (int i = 0; i < 16; i++) begin
            checks++; if (r_data !== 8'(i) || rx_empty !== 1'b0) begin
                errors++; $display("FAIL ovr_read%0d got %h empty=%b want %h 0", i, r_data, rx_empty, 8'(i)); end
            pop_pulse();
            void'(model_q.pop_front());
        end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL ovr_drained got %b want 1", rx_empty); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int o, pe0;
        pe0 = pe_cnt;
        o = model_frame(8'h07, 1'b0, 1'b1);
        drive_frame(8'h07, 1'b0, 1'b1);
        checks++; if (o != O_PE || pe_cnt - pe0 != 1 || rx_empty !== 1'b1) begin
            errors++; $display("FAIL parity_bad got pe=%0d empty=%b want 1 1", pe_cnt - pe0, rx_empty); end
        pe0 = pe_cnt;
        o = model_frame(8'h07, 1'b1, 1'b1);
        drive_frame(8'h07, 1'b1, 1'b1);
        checks++; if (pe_cnt != pe0 || r_data !== 8'h07 || rx_empty !== 1'b0) begin
            errors++; $display("FAIL parity_good got pe=%0d data=%h want 0 07", pe_cnt - pe0, r_data); end
        pop_pulse();
        void'(model_q.pop_front());
    endtask
`endif

    task automatic test_random();
        int o, fe0, pe0, ov0, nr;
        logic [7:0] d;
        logic p, stop;
        for (int f = 0; f < 24; f++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            p    = (^d) ^ ($urandom_range(0, 5) == 0);
            fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
            repeat ($urandom_range(0, 30)) @(negedge clk);
            o = model_frame(d, p, stop);
            drive_frame(d, p, stop);
            checks++; if (fe_cnt - fe0 != int'(o == O_FE) || pe_cnt - pe0 != int'(o == O_PE) || ov_cnt - ov0 != int'(o == O_OV)) begin
                errors++; $display("FAIL rand%0d_pulses d=%h got fe=%0d pe=%0d ov=%0d want outcome %0d", f, d, fe_cnt-fe0, pe_cnt-pe0, ov_cnt-ov0, o); end
            checks++; if (rx_empty !== (model_q.size() == 0) || rx_full !== (model_q.size() == 16)) begin
                errors++; $display("FAIL rand%0d_level got empty=%b full=%b want size %0d", f, rx_empty, rx_full, model_q.size()); end
            nr = $urandom_range(0, 1);
            for (int r = 0; r < nr; r++) begin
                if (model_q.size() != 0) begin
                    checks++; if (r_data !== model_q[0]) begin
                        errors++; $display("FAIL rand%0d_read got %h want %h", f, r_data, model_q[0]); end
                    void'(model_q.pop_front());
                end
                pop_pulse();
            end
        end
        while (model_q.size() != 0) begin
            checks++; if (r_data !== model_q[0] || rx_empty !== 1'b0) begin
                errors++; $display("FAIL drain_read got %h empty=%b want %h 0", r_data, rx_empty, model_q[0]); end
            void'(model_q.pop_front());
            pop_pulse();
        end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", rx_empty); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            void'(model_frame(d, ^d, 1'b1));
            drive_frame(d, ^d, 1'b1);
        end
        checks++; if (rx_empty !== 1'b0 || r_data !== model_q[0]) begin
            errors++; $display("FAIL pre_reset got %h empty=%b want %h 0", r_data, rx_empty, model_q[0]); end
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b1; repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b0; repeat (BIT_CLKS / 2) @(negedge clk);
        reset = 1'b0;
        rx = 1'b1;
        model_q.delete();
        repeat (4) @(negedge clk);
        checks++; if (rx_empty !== 1'b1 || rx_full !== 1'b0 || r_data !== 8'h00) begin
            errors++; $display("FAIL mid_reset got empty=%b full=%b data=%h want 1 0 00", rx_empty, rx_full, r_data); end
        checks++; if ({frame_err, parity_err, overrun} !== 3'b000) begin
            errors++; $display("FAIL mid_reset_pulses got %b want 000", {frame_err, parity_err, overrun}); end
        reset = 1'b1;
        repeat (100) @(negedge clk);
        void'(model_frame(8'h5A, ^8'h5A, 1'b1));
        drive_frame(8'h5A, ^8'h5A, 1'b1);
        checks++; if (r_data !== 8'h5A || rx_empty !== 1'b0) begin
            errors++; $display("FAIL post_reset got %h empty=%b want 5a 0", r_data, rx_empty); end
        pop_pulse();
        void'(model_q.pop_front());
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL post_reset_only got empty=%b want 1", rx_empty); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        test_reset_mid();
        checks++; if (wide_cnt != 0) begin errors++; $display("FAIL pulse_width_final got %0d wide want 0", wide_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the debug UART: deserialises an 8N1 (optionally 8E1) line with 16× oversampling and buffers received bytes in a 16-entry FIFO for the consumer logic. It shares the `s_tick` oversampling strobe from the existing baud-rate generator with the transmit path. It exposes a first-word-fall-through read port plus per-frame error pulses.

## Interface
- `DBIT`, 8: data bits per frame, 5..8.
- `SB_TICK`, 16: oversampling ticks in the stop bit (16 = 1 stop bit).
- `FIFO_AW`, 4: FIFO address width, so depth is 2^FIFO_AW = 16.
- `clk` in 1: system clock, the only clock.
- `reset` in 1: asynchronous, active-low; clears all state.
- `rx` in 1: serial line, asynchronous to `clk`, idle high.
- `s_tick` in 1: one-`clk` strobe at 16× baud.
- `rd_uart` in 1: pop the FIFO head.
- `r_data` out 8: FIFO head, right-aligned; bits above `DBIT` are 0.
- `rx_empty` out 1: FIFO empty.
- `rx_full` out 1: FIFO holds 2^FIFO_AW entries.
- `frame_err` out 1: one-cycle pulse; stop bit sampled 0, byte dropped.
- `parity_err` out 1: one-cycle pulse; parity mismatch, byte dropped.
- `overrun` out 1: one-cycle pulse; good byte arrived while the FIFO was full, byte dropped.

## Operation
- `rx` passes through a 2-flop synchroniser (`rx_s`); both flops reset to 1.
- The FSM has states IDLE, START, DATA, PARITY (only with the macro) and STOP. It uses a 4-bit tick counter `s`, a 3-bit bit counter `n` and an 8-bit shift register `b`. It advances only in cycles where `s_tick`=1, except IDLE.
- IDLE: when `rx_s`=0, go to START with `s`=0. This does not wait for a tick.
- START: on each tick, if `s`=7, check `rx_s`. If `rx_s`=0, go to DATA with `s`=0 and `n`=0. If `rx_s`=1, the start was a glitch: go back to IDLE and write nothing. Otherwise `s++`.
- DATA: on each tick, if `s`=15, set `s`=0 and shift `rx_s` into `b`, LSB first. If `n`=DBIT-1, go to PARITY or STOP; otherwise `n++`. If `s`≠15, `s++`.
- PARITY: at `s`=15, sample the parity bit. The check is even parity: the XOR of the data bits and the parity bit must be 0.
- STOP: at `s`=SB_TICK-1, sample `rx_s` and go to IDLE. Then exactly one of the following applies, in this priority order:
  - stop bit = 0: pulse `frame_err`.
  - parity bad: pulse `parity_err`.
  - FIFO full and `rd_uart`=0: pulse `overrun`.
  - otherwise: write the byte to the FIFO.
- Errored or overrun bytes are never written.
- FIFO reads: `rd_uart` when empty is ignored.
- FIFO write and read in the same cycle:
  - Full: both succeed and the count is unchanged.
  - Empty: the write succeeds, the read is ignored.
- Pointers wrap modulo 2^FIFO_AW. `rx_full` and `rx_empty` come from a pointer-difference count with FIFO_AW+1 bits.
- Reset mid-frame: the FSM returns to IDLE, the FIFO is emptied and all pulses clear. The next falling edge after reset starts a fresh frame.

## Timing
- Reset values:
  - `rx_empty`=1
  - `rx_full`=0
  - `r_data`=0
  - `frame_err`=`parity_err`=`overrun`=0
  - FSM=IDLE, `rx_s`=1
- Input latency: 2 `clk` cycles from `rx` to `rx_s`.
- Start detection: the start bit is verified 8 ticks after the falling edge, i.e. mid-bit. Every later bit is sampled 16 ticks apart.
- Completion: the FIFO write, or the error pulse, is registered on the `clk` edge that processes the final stop tick. From the next cycle, `rx_empty`=0 and `r_data` is valid.
- Error pulses last exactly 1 `clk` cycle.
- Reads: `r_data` is first-word-fall-through. A pop on edge k shows the next entry, or asserts `rx_empty`, after edge k.
- No combinational path from `rx` to any output.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - A PARITY state follows DATA; the frame is DBIT+1 bits after start.
  - A mismatch drops the byte and pulses `parity_err`.
- `UART_RX_PARITY_EN` undefined:
  - No PARITY state; DATA goes directly to STOP.
  - `parity_err` is tied to 0.

## Test plan
Bench setup: `s_tick` every 4 `clk` cycles, giving a 64-cycle bit period.
- Send 0xA5 as 8N1 → one write; `r_data`=0xA5 and `rx_empty`=0. One `rd_uart` pulse → `rx_empty`=1.
- Drive `rx` low for 12 cycles, then high → no write, no error pulses, FSM back in IDLE.
- Send 0x3C with stop bit 0 → one-cycle `frame_err`; `rx_empty` stays 1.
- Send 0x00..0x10 (17 bytes) with no reads:
  - `rx_full`=1 after byte 16.
  - Byte 17 gives one `overrun` pulse.
  - 16 reads return 0x00..0x0F.
- With `UART_RX_PARITY_EN`: send 0x07 with parity bit 0 → `parity_err` pulse, nothing written. Send 0x07 with parity bit 1 → `r_data`=0x07.
- Assert `reset` low mid-DATA with 3 bytes buffered → all outputs at reset values. After release, send 0x5A → `r_data`=0x5A, and it is the only entry.
